// File: rtl/rtl_bmu_seq_pkg.sv
// Shared types for the multi-cycle bit-manipulation unit: opcode and FSM encodings,
// the request record, and small opcode-class helpers.
package rtl_pkg;

   typedef enum logic [4:0] {
      CLZ, CTZ, CPOP, SEXTB, SEXTH, MIN, MAX, MINU, MAXU,
      ROL, ROR, BSET, BCLR, BINV, BEXT, GREV, GORC
   } rtl_bmu_op_e;

   typedef enum logic [1:0] {
      IDLE, EXEC, DONE
   } rtl_bmu_state_e;

   localparam int unsigned RTL_BMU_XLEN = 32;
   localparam int unsigned RTL_BMU_TAGW = 4;

   typedef struct packed {
      rtl_bmu_op_e              op;
      logic [RTL_BMU_XLEN-1:0]  a;
      logic [RTL_BMU_XLEN-1:0]  b;
      logic [RTL_BMU_TAGW-1:0]  tag;
   } rtl_bmu_req_t;

   function automatic logic f_bmu_is_count(input rtl_bmu_op_e op);
      return (op == CLZ) || (op == CTZ) || (op == CPOP);
   endfunction

   function automatic logic f_bmu_is_butterfly(input rtl_bmu_op_e op);
      return (op == GREV) || (op == GORC);
   endfunction

endpackage

// File: rtl/rtl_bmu_seq_grev_stage.sv
// One grev/gorc butterfly stage (swap distance 2^i_stage); only built with RTL_BMU_GREV_EN.
`ifdef RTL_BMU_GREV_EN
module rtl_bmu_grev_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0]         i_data,
   input  logic [$clog2(XLEN)-1:0] i_stage,
   input  logic                    i_en,
   input  logic                    i_orc,
   output logic [XLEN-1:0]         o_data
);

   localparam int unsigned SW = $clog2(XLEN);

   logic [XLEN-1:0] w_swap;

   always_comb begin
      w_swap = i_data;
      for (int unsigned k = 0; k < SW; k++) begin
         if (i_stage == SW'(k)) begin
            for (int unsigned i = 0; i < XLEN; i++) begin
               w_swap[SW'(i)] = i_data[SW'(i ^ (32'd1 << k))];
            end
         end
      end
   end

   always_comb begin
      o_data = i_data;
      if (i_en) o_data = i_orc ? (i_data | w_swap) : w_swap;
   end

endmodule
`endif

// File: rtl/rtl_bmu_seq.sv
// Multi-cycle Zbb/Zbs bit-manipulation execute unit with valid/ready, tags and flush.
// Define RTL_BMU_GREV_EN to build the staged grev/gorc datapath; otherwise those ops flag illegal.
module rtl_bmu_seq
   import rtl_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CHUNK = 8,
   parameter int unsigned TAGW  = 4
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  rtl_bmu_op_e       in_op,
   input  logic [XLEN-1:0]   in_a,
   input  logic [XLEN-1:0]   in_b,
   input  logic [TAGW-1:0]   in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic [TAGW-1:0]   out_tag,
   output logic              out_illegal,
   output logic              busy
);

   localparam int unsigned SHW    = $clog2(XLEN);
   localparam int unsigned NCHUNK = XLEN / CHUNK;
   localparam int unsigned MAXS   = (NCHUNK > SHW) ? NCHUNK : SHW;
   localparam int unsigned STEPW  = $clog2(MAXS) + 1;
   localparam int unsigned CW     = $clog2(XLEN) + 1;
   localparam int unsigned CHW    = $clog2(CHUNK) + 1;
   localparam int unsigned CIW    = $clog2(CHUNK);

   rtl_bmu_state_e   r_state;
   rtl_bmu_op_e      r_op;
   logic [XLEN-1:0]  r_work;
   logic [XLEN-1:0]  r_b;
   logic [TAGW-1:0]  r_tag;
   logic [STEPW-1:0] r_step;
   logic [STEPW-1:0] r_last;
   logic [CW-1:0]    r_acc;
   logic             r_found;
   logic [XLEN-1:0]  r_result;
   logic             r_illegal;

   logic             w_accept;
   logic [CHUNK-1:0] w_chunk_hi;
   logic [CHUNK-1:0] w_chunk_lo;
   logic [SHW-1:0]   w_idx;
   logic [SHW:0]     w_inv;
   logic [XLEN-1:0]  w_onehot;
   logic [XLEN-1:0]  w_work_nxt;
   logic [CW-1:0]    w_acc_nxt;
   logic             w_found_nxt;
   logic [XLEN-1:0]  w_single;
   logic [XLEN-1:0]  w_final;
   logic             w_illegal;

   function automatic logic [CHW-1:0] f_pop(input logic [CHUNK-1:0] v);
      logic [CHW-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < CHUNK; i++) n = n + CHW'(v[CIW'(i)]);
      return n;
   endfunction

   function automatic logic [CHW-1:0] f_lz(input logic [CHUNK-1:0] v);
      logic [CHW-1:0] n;
      logic           hit;
      n   = '0;
      hit = 1'b0;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         if (v[CIW'(CHUNK-1-i)]) hit = 1'b1;
         else if (!hit)          n   = n + CHW'(1);
      end
      return n;
   endfunction

   function automatic logic [CHW-1:0] f_tz(input logic [CHUNK-1:0] v);
      logic [CHW-1:0] n;
      logic           hit;
      n   = '0;
      hit = 1'b0;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         if (v[CIW'(i)]) hit = 1'b1;
         else if (!hit)  n   = n + CHW'(1);
      end
      return n;
   endfunction

   function automatic logic [STEPW-1:0] f_last(input rtl_bmu_op_e op);
      if (f_bmu_is_count(op)) return STEPW'(NCHUNK - 1);
`ifdef RTL_BMU_GREV_EN
      if (f_bmu_is_butterfly(op)) return STEPW'(SHW - 1);
`endif
      return '0;
   endfunction

   assign w_accept   = in_valid & in_ready;
   assign w_chunk_hi = r_work[XLEN-1 -: CHUNK];
   assign w_chunk_lo = r_work[CHUNK-1:0];
   assign w_idx      = r_b[SHW-1:0];
   assign w_inv      = (SHW+1)'(XLEN) - (SHW+1)'(w_idx);
   assign w_onehot   = XLEN'(1) << w_idx;

`ifdef RTL_BMU_GREV_EN
   logic [XLEN-1:0] w_grev_out;
   logic [SHW-1:0]  w_stage;

   // One stage per EXEC cycle: the step counter selects both distance and enable bit.
   assign w_stage = SHW'(r_step);

   rtl_bmu_grev_stage #(.XLEN(XLEN)) u_grev (
      .i_data  (r_work),
      .i_stage (w_stage),
      .i_en    (r_b[w_stage]),
      .i_orc   (r_op == GORC),
      .o_data  (w_grev_out)
   );
`endif

   // CLZ/CTZ stop accumulating at the first nonzero chunk but keep stepping.
   always_comb begin
      w_work_nxt  = r_work;
      w_acc_nxt   = r_acc;
      w_found_nxt = r_found;
      case (r_op)
         CLZ: begin
            w_work_nxt = r_work << CHUNK;
            if (!r_found) begin
               w_acc_nxt   = r_acc + CW'(f_lz(w_chunk_hi));
               w_found_nxt = |w_chunk_hi;
            end
         end
         CTZ: begin
            w_work_nxt = r_work >> CHUNK;
            if (!r_found) begin
               w_acc_nxt   = r_acc + CW'(f_tz(w_chunk_lo));
               w_found_nxt = |w_chunk_lo;
            end
         end
         CPOP: begin
            w_work_nxt = r_work >> CHUNK;
            w_acc_nxt  = r_acc + CW'(f_pop(w_chunk_lo));
         end
`ifdef RTL_BMU_GREV_EN
         GREV, GORC: w_work_nxt = w_grev_out;
`endif
         default: ;
      endcase
   end

   always_comb begin
      w_single = '0;
      case (r_op)
         SEXTB: w_single = {{(XLEN-8){r_work[7]}}, r_work[7:0]};
         SEXTH: w_single = {{(XLEN-16){r_work[15]}}, r_work[15:0]};
         MIN:   w_single = ($signed(r_work) < $signed(r_b)) ? r_work : r_b;
         MAX:   w_single = ($signed(r_work) < $signed(r_b)) ? r_b : r_work;
         MINU:  w_single = (r_work < r_b) ? r_work : r_b;
         MAXU:  w_single = (r_work < r_b) ? r_b : r_work;
         ROL:   w_single = (r_work << w_idx) | (r_work >> w_inv);
         ROR:   w_single = (r_work >> w_idx) | (r_work << w_inv);
         BSET:  w_single = r_work | w_onehot;
         BCLR:  w_single = r_work & ~w_onehot;
         BINV:  w_single = r_work ^ w_onehot;
         BEXT:  w_single = {{(XLEN-1){1'b0}}, r_work[w_idx]};
         default: w_single = '0;
      endcase
   end

   always_comb begin
      w_illegal = 1'b0;
      if (f_bmu_is_count(r_op)) begin
         w_final = XLEN'(w_acc_nxt);
      end else if (f_bmu_is_butterfly(r_op)) begin
`ifdef RTL_BMU_GREV_EN
         w_final   = w_work_nxt;
`else
         w_final   = '0;
         w_illegal = 1'b1;
`endif
      end else begin
         w_final = w_single;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state   <= IDLE;
         r_op      <= CLZ;
         r_work    <= '0;
         r_b       <= '0;
         r_tag     <= '0;
         r_step    <= '0;
         r_last    <= '0;
         r_acc     <= '0;
         r_found   <= 1'b0;
         r_result  <= '0;
         r_illegal <= 1'b0;
      end else if (flush) begin
         r_state <= IDLE;
         r_step  <= '0;
      end else if (w_accept) begin
         r_state <= EXEC;
         r_op    <= in_op;
         r_work  <= in_a;
         r_b     <= in_b;
         r_tag   <= in_tag;
         r_step  <= '0;
         r_last  <= f_last(in_op);
         r_acc   <= '0;
         r_found <= 1'b0;
      end else begin
         case (r_state)
            EXEC: begin
               r_work  <= w_work_nxt;
               r_acc   <= w_acc_nxt;
               r_found <= w_found_nxt;
               if (r_step == r_last) begin
                  r_state   <= DONE;
                  r_result  <= w_final;
                  r_illegal <= w_illegal;
               end else begin
                  r_step <= r_step + STEPW'(1);
               end
            end
            DONE:    if (out_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready    = ((r_state == IDLE) | ((r_state == DONE) & out_ready)) & ~flush;
   assign out_valid   = (r_state == DONE);
   assign out_result  = r_result;
   assign out_tag     = r_tag;
   assign out_illegal = r_illegal;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_rtl_bmu_seq.sv
// Directed self-checking bench for rtl_bmu_seq (XLEN=32, CHUNK=8); tracks RTL_BMU_GREV_EN.
`timescale 1ns/1ps
module tb_rtl_bmu_seq;
   import rtl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   rtl_bmu_op_e in_op = CLZ;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic [3:0]  out_tag;
   logic        out_illegal;
   logic        busy;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   always #5 clk = ~clk;

   rtl_bmu_seq #(.XLEN(32), .CHUNK(8), .TAGW(4)) dut (
      .clk         (clk),
      .rst_l       (rst_l),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_tag     (out_tag),
      .out_illegal (out_illegal),
      .busy        (busy)
   );

   typedef struct {
      rtl_bmu_req_t req;
      logic [31:0]  exp;
      logic         ill;
      int unsigned  lat;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mkv(input rtl_bmu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] tag, input logic [31:0] exp, input logic ill,
                                input int unsigned lat);
      vec_t v;
      v.req.op  = op;
      v.req.a   = a;
      v.req.b   = b;
      v.req.tag = tag;
      v.exp     = exp;
      v.ill     = ill;
      v.lat     = lat;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input rtl_bmu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      in_valid = 1'b1;
   endtask

   // Counts negedges after the accept edge until out_valid; 20 means it never came.
   task automatic wait_out(output int unsigned cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid && cyc < 20);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int unsigned cyc;
      @(negedge clk);
      out_ready = 1'b1;
      drive(v.req.op, v.req.a, v.req.b, v.req.tag);
      #1 chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_out(cyc);
      chk({nm, "_latency"}, cyc, v.lat);
      chk({nm, "_result"}, out_result, v.exp);
      chk({nm, "_tag"}, 32'(out_tag), 32'(v.req.tag));
      chk({nm, "_illegal"}, 32'(out_illegal), 32'(v.ill));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned cyc;
      bit          seen;

      vq.push_back(mkv(CPOP,  32'hF0F0_0001, 32'h0,  4'h1, 32'd9,  1'b0, 5));
      vq.push_back(mkv(CLZ,   32'h0000_0000, 32'h0,  4'h2, 32'd32, 1'b0, 5));
      vq.push_back(mkv(CTZ,   32'h0000_0100, 32'h0,  4'h3, 32'd8,  1'b0, 5));
      vq.push_back(mkv(CLZ,   32'h0001_0000, 32'h0,  4'h4, 32'd15, 1'b0, 5));
      vq.push_back(mkv(CTZ,   32'h0000_0000, 32'h0,  4'h5, 32'd32, 1'b0, 5));
      vq.push_back(mkv(CPOP,  32'hFFFF_FFFF, 32'h0,  4'h6, 32'd32, 1'b0, 5));
      vq.push_back(mkv(CLZ,   32'h8000_0000, 32'h0,  4'h7, 32'd0,  1'b0, 5));
      vq.push_back(mkv(SEXTB, 32'h0000_0080, 32'h0,  4'h8, 32'hFFFF_FF80, 1'b0, 2));
      vq.push_back(mkv(SEXTH, 32'h0000_7FFF, 32'h0,  4'h9, 32'h0000_7FFF, 1'b0, 2));
      vq.push_back(mkv(SEXTH, 32'h1234_8000, 32'h0,  4'hA, 32'hFFFF_8000, 1'b0, 2));
      vq.push_back(mkv(MIN,   32'hFFFF_FFFF, 32'd1,  4'hB, 32'hFFFF_FFFF, 1'b0, 2));
      vq.push_back(mkv(MAX,   32'hFFFF_FFFF, 32'd1,  4'hC, 32'd1, 1'b0, 2));
      vq.push_back(mkv(MINU,  32'hFFFF_FFFF, 32'd1,  4'hD, 32'd1, 1'b0, 2));
      vq.push_back(mkv(MAXU,  32'hFFFF_FFFF, 32'd1,  4'hE, 32'hFFFF_FFFF, 1'b0, 2));
      vq.push_back(mkv(ROL,   32'h8000_0001, 32'd4,  4'hF, 32'h0000_0018, 1'b0, 2));
      vq.push_back(mkv(ROL,   32'h8000_0001, 32'd32, 4'h1, 32'h8000_0001, 1'b0, 2));
      vq.push_back(mkv(ROR,   32'h0000_0001, 32'd1,  4'h2, 32'h8000_0000, 1'b0, 2));
      vq.push_back(mkv(BSET,  32'h0000_0000, 32'd31, 4'h3, 32'h8000_0000, 1'b0, 2));
      vq.push_back(mkv(BCLR,  32'hFFFF_FFFF, 32'h21, 4'h4, 32'hFFFF_FFFD, 1'b0, 2));
      vq.push_back(mkv(BINV,  32'h0000_000F, 32'd3,  4'h5, 32'h0000_0007, 1'b0, 2));
      vq.push_back(mkv(BEXT,  32'h8000_0000, 32'd31, 4'h6, 32'd1, 1'b0, 2));
      vq.push_back(mkv(BEXT,  32'h8000_0000, 32'd30, 4'h7, 32'd0, 1'b0, 2));
`ifdef RTL_BMU_GREV_EN
      vq.push_back(mkv(GREV,  32'h0000_0001, 32'd31, 4'h8, 32'h8000_0000, 1'b0, 6));
      vq.push_back(mkv(GORC,  32'h0000_0010, 32'd7,  4'h9, 32'h0000_00FF, 1'b0, 6));
`else
      vq.push_back(mkv(GREV,  32'h0000_0001, 32'd31, 4'h8, 32'h0, 1'b1, 2));
      vq.push_back(mkv(GORC,  32'h0000_0010, 32'd7,  4'h9, 32'h0, 1'b1, 2));
`endif

      repeat (3) @(negedge clk);
      rst_l = 1'b1;
      #1;
      chk("reset_in_ready",    32'(in_ready),    32'd1);
      chk("reset_out_valid",   32'(out_valid),   32'd0);
      chk("reset_out_result",  out_result,       32'd0);
      chk("reset_out_tag",     32'(out_tag),     32'd0);
      chk("reset_out_illegal", 32'(out_illegal), 32'd0);
      chk("reset_busy",        32'(busy),        32'd0);

      for (int i = 0; i < vq.size(); i++) begin
         run_vec(vq[i], $sformatf("%s_%0d", vq[i].req.op.name(), i));
      end

      // Back-pressure: result held, then a new request accepted in the release cycle.
      @(negedge clk);
      out_ready = 1'b0;
      drive(ROR, 32'h0000_0001, 32'd1, 4'h5);
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_out(cyc);
      chk("bp_latency", cyc, 32'd2);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp_hold_result_%0d", k), out_result, 32'h8000_0000);
         chk($sformatf("bp_hold_tag_%0d", k), 32'(out_tag), 32'h5);
         chk($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp_hold_in_ready_%0d", k), 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      drive(MAXU, 32'd3, 32'd7, 4'h6);
      #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("bp_b2b_busy", 32'(busy), 32'd1);
      chk("bp_b2b_valid_low", 32'(out_valid), 32'd0);
      wait_out(cyc);
      chk("bp_b2b_latency", cyc, 32'd2);
      chk("bp_b2b_result", out_result, 32'd7);
      chk("bp_b2b_tag", 32'(out_tag), 32'h6);

      // Flush during the second EXEC cycle of CPOP, with a competing request.
      @(negedge clk);
      drive(CPOP, 32'h0000_00FF, 32'h0, 4'h9);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 flush = 1'b1;
      drive(MAX, 32'd1, 32'd2, 4'hE);
      @(negedge clk);
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      chk("flush_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_after_in_ready", 32'(in_ready), 32'd1);
      chk("flush_after_busy", 32'(busy), 32'd0);
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("flush_no_result", 32'(seen), 32'd0);

      // Asynchronous reset while CPOP is in EXEC.
      @(negedge clk);
      drive(CPOP, 32'h0000_000F, 32'h0, 4'hB);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      #2 rst_l = 1'b0;
      #1;
      chk("rst_mid_in_ready",    32'(in_ready),    32'd1);
      chk("rst_mid_out_valid",   32'(out_valid),   32'd0);
      chk("rst_mid_out_result",  out_result,       32'd0);
      chk("rst_mid_out_tag",     32'(out_tag),     32'd0);
      chk("rst_mid_out_illegal", 32'(out_illegal), 32'd0);
      chk("rst_mid_busy",        32'(busy),        32'd0);
      @(negedge clk);
      rst_l = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid || busy) seen = 1'b1;
      end
      chk("rst_mid_no_result", 32'(seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rtl_bmu_seq.md
# rtl_bmu_seq

Parametrised, multi-cycle bit-manipulation execute unit; successor to the single-cycle Zbb/Zbs datapath driven by `rtl_alu_pkt_t`. Generalises operand width (`XLEN`) and count-chunk width (`CHUNK`). Adds iterative count operations and staged grev/gorc, plus valid/ready handshakes, tagging and flush. It sits beside the ALU in the execute stage and returns one tagged result per accepted request.

## Interface
- `XLEN`, 32: operand/result width; power of two, 32 or 64.
- `CHUNK`, 8: bits examined per cycle by clz/ctz/cpop; power of two, divides `XLEN`, at least 2.
- `TAGW`, 4: request tag width.
- `clk` in 1: clock.
- `rst_l` in 1: **single clock; asynchronous, active-low reset.**
- `flush` in 1: kill any in-flight request.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request.
- `in_op` in 5: operation, type `rtl_bmu_op_e`.
- `in_a` in `XLEN`: operand A.
- `in_b` in `XLEN`: operand B (shift amount or second operand).
- `in_tag` in `TAGW`: request tag.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out `XLEN`: result.
- `out_tag` out `TAGW`: tag of the result.
- `out_illegal` out 1: operation not supported in this build.
- `busy` out 1: FSM not in IDLE.

## Operation
- **Accept:** a request is accepted on a cycle where `in_valid & in_ready`. A/B/op/tag are registered.
- **FSM states:**
  - IDLE: `in_ready=1`. Accept moves to EXEC.
  - EXEC: iterate until the step counter reaches its target, then go to DONE.
  - DONE: `out_valid=1`. When `out_ready` is high, go to IDLE; if `in_valid` is also high, accept back-to-back and go to EXEC.
- **`in_ready` rule:** `in_ready = (IDLE | (DONE & out_ready)) & ~flush`.
- **Single-step ops** (1 EXEC cycle): SEXTB, SEXTH, MIN, MAX, MINU, MAXU, ROL, ROR, BSET, BCLR, BINV, BEXT.
- **Count ops** (CLZ, CTZ, CPOP):
  - Take `XLEN/CHUNK` EXEC cycles.
  - CLZ scans MSB chunk first; CTZ scans LSB chunk first. Each accumulates until the first nonzero chunk is found; later chunks are ignored, but the latency stays fixed.
  - CPOP adds the popcount of each chunk.
- **GREV/GORC:** `$clog2(XLEN)` EXEC cycles, one butterfly stage per cycle, stage k (distance 2^k) enabled by `in_b[k]`. GORC ORs the swapped value with the current value.
- **Width rules:**
  - Shift and bit index = `in_b[$clog2(XLEN)-1:0]`.
  - CLZ/CTZ of 0 = `XLEN`.
  - Count results are zero-extended.
  - SEXT results are sign-extended from bit 7/15.
  - BEXT = `{XLEN-1 zeros, in_a[idx]}`.
  - MIN/MAX are signed; MINU/MAXU are unsigned.
- **Flush:** in any state, the FSM returns to IDLE at the next edge and `out_valid` drops. No result is produced for the killed request. A request presented during `flush` is not accepted.
- **Reset mid-operation:** everything is cleared and the request is lost.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_result=0`, `out_tag=0`, `out_illegal=0`, `busy=0`; FSM in IDLE; counters 0.
- **Latency** from the accept edge to `out_valid` high: N+1 cycles, where N is the EXEC count (single-step op: 2, i.e. `out_valid` in the second cycle after the accept cycle).
- **Throughput:** with `out_ready` tied high, one result per N+1 cycles.
- **Back-pressure:** `out_result`, `out_tag` and `out_illegal` are held stable while `out_valid & ~out_ready`.
- **Step counter:** width `$clog2(max(XLEN/CHUNK, $clog2(XLEN)))+1`; it does not wrap during an operation.

## Configuration
- **Macro `RTL_BMU_GREV_EN`.**
- **Defined:** GREV/GORC are implemented as above.
- **Undefined:** the butterfly stage is not compiled. GREV/GORC take 1 EXEC cycle and return `out_result=0`, `out_illegal=1`. All other ops keep `out_illegal=0`.

## Structure
- Shared package `rtl_pkg` holds:
  - `rtl_bmu_op_e`: 5-bit enum CLZ, CTZ, CPOP, SEXTB, SEXTH, MIN, MAX, MINU, MAXU, ROL, ROR, BSET, BCLR, BINV, BEXT, GREV, GORC.
  - `rtl_bmu_state_e`: IDLE, EXEC, DONE.
  - `rtl_bmu_req_t`: packed struct of op, a, b, tag.
- Sub-module `rtl_bmu_grev_stage`: combinational, parameters `XLEN`; inputs data, stage index, enable, orc; output data. Instantiated once and time-multiplexed by the step counter; enclosed in `RTL_BMU_GREV_EN`.

## Test plan
(All scenarios use XLEN=32, CHUNK=8.)
- CPOP, `in_a=0xF0F0_0001` → `out_result=9`, `out_valid` 5 cycles after accept, tag echoed.
- CLZ, `in_a=0` → 32. CTZ, `in_a=0x0000_0100` → 8. CLZ, `in_a=0x0001_0000` → 15.
- GREV, `in_a=0x0000_0001`, `in_b=31` → `0x8000_0000` after 6 cycles. GORC, `in_a=0x0000_0010`, `in_b=7` → `0x0000_00FF`.
- Back-pressure: ROR, `in_a=0x0000_0001`, `in_b=1` → `0x8000_0000`. Hold `out_ready=0` for 3 cycles: result stable, `in_ready=0`. Raise `out_ready` with a new `in_valid`: accepted in that same cycle.
- Flush in the 2nd EXEC cycle of CPOP → no `out_valid` ever for that tag; `in_ready=1` the next cycle. Repeat with `rst_l` asserted mid-operation: all outputs return to reset values immediately.
- Build without `RTL_BMU_GREV_EN`: GREV → `out_result=0`, `out_illegal=1` after 2 cycles. MAX(`0xFFFF_FFFF`, 1) → 1 with `out_illegal=0`.
